// File: rtl/p_signal_actuator.sv
// Door-lock / buzzer actuator driven by a 2-bit command level; a change of cmd starts a timed sequence.
// Latency: outputs registered, one clock after cmd changes. No backpressure; changes arriving during a sequence are dropped.
module p_signal_actuator #(
    parameter int UNLOCK_CYCLES = 50000000,
    parameter int BEEP_CYCLES   = 5000000,
    parameter int GAP_CYCLES    = 5000000,
    parameter int BEEP_COUNT    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] cmd,
    output logic       lock_open,
    output logic       buzzer,
    output logic       alarm,
    output logic       busy,
    output logic       done,
    output logic [7:0] deny_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UNLOCK   = 3'd1,
        BEEP_ON  = 3'd2,
        BEEP_OFF = 3'd3,
        ALARM    = 3'd4
    } state_t;

    localparam logic [1:0]  CMD_CLEAR = 2'b00;
    localparam logic [1:0]  CMD_GRANT = 2'b01;
    localparam logic [1:0]  CMD_DENY  = 2'b10;
    localparam logic [1:0]  CMD_ALARM = 2'b11;
    localparam logic [31:0] UNLOCK_LD = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] BEEP_LD   = 32'(BEEP_CYCLES - 1);
    localparam logic [31:0] GAP_LD    = 32'(GAP_CYCLES - 1);
    localparam logic [3:0]  BEEP_N    = 4'(BEEP_COUNT);

    state_t      state, next_state;
    logic [1:0]  cmd_q;
    logic [31:0] dur_cnt, dur_nxt;
    logic [3:0]  pulse_cnt, pulse_nxt;
    logic        done_nxt, lock_nxt, buzzer_nxt, alarm_nxt, busy_nxt;
    logic        new_cmd, deny_accept;

    assign new_cmd     = (cmd != cmd_q);
    assign deny_accept = (state == IDLE) && new_cmd && (cmd == CMD_DENY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd_q      <= CMD_CLEAR;
            dur_cnt    <= '0;
            pulse_cnt  <= '0;
            lock_open  <= 1'b0;
            buzzer     <= 1'b0;
            alarm      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            deny_count <= '0;
        end else begin
            state     <= next_state;
            cmd_q     <= cmd;
            dur_cnt   <= dur_nxt;
            pulse_cnt <= pulse_nxt;
            lock_open <= lock_nxt;
            buzzer    <= buzzer_nxt;
            alarm     <= alarm_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            if (deny_accept && (deny_count != 8'hFF))
                deny_count <= deny_count + 8'd1;
        end
    end

    always_comb begin
        next_state = state;
        dur_nxt    = dur_cnt;
        pulse_nxt  = pulse_cnt;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (new_cmd) begin
                    case (cmd)
                        CMD_GRANT: begin next_state = UNLOCK;  dur_nxt = UNLOCK_LD; end
                        CMD_DENY:  begin next_state = BEEP_ON; dur_nxt = BEEP_LD; pulse_nxt = '0; end
                        CMD_ALARM: next_state = ALARM;
                        default:   next_state = IDLE;
                    endcase
                end
            end
            UNLOCK: begin
                if (new_cmd && cmd == CMD_ALARM) begin
                    next_state = ALARM;
                end else if (dur_cnt == '0) begin
                    next_state = IDLE;
                    done_nxt   = 1'b1;
                end else begin
                    dur_nxt = dur_cnt - 32'd1;
                end
            end
            BEEP_ON: begin
                if (new_cmd && cmd == CMD_ALARM) begin
                    next_state = ALARM;
                end else if (dur_cnt == '0) begin
                    // pulse_cnt counts completed pulses; the last pulse has no trailing gap
                    if ((pulse_cnt + 4'd1) < BEEP_N) begin
                        next_state = BEEP_OFF;
                        dur_nxt    = GAP_LD;
                        pulse_nxt  = pulse_cnt + 4'd1;
                    end else begin
                        next_state = IDLE;
                        done_nxt   = 1'b1;
                    end
                end else begin
                    dur_nxt = dur_cnt - 32'd1;
                end
            end
            BEEP_OFF: begin
                if (new_cmd && cmd == CMD_ALARM) begin
                    next_state = ALARM;
                end else if (dur_cnt == '0) begin
                    next_state = BEEP_ON;
                    dur_nxt    = BEEP_LD;
                end else begin
                    dur_nxt = dur_cnt - 32'd1;
                end
            end
            ALARM: begin
                if (new_cmd && cmd == CMD_CLEAR)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (next_state == IDLE || next_state == ALARM) begin
            dur_nxt   = '0;
            pulse_nxt = '0;
        end
    end

    always_comb begin
        lock_nxt   = (next_state == UNLOCK);
        buzzer_nxt = (next_state == BEEP_ON) || (next_state == ALARM);
        alarm_nxt  = (next_state == ALARM);
        busy_nxt   = (next_state != IDLE);
    end

endmodule

// File: tb/tb_p_signal_actuator.sv
// Bench for p_signal_actuator with short timing parameters; expected output vectors are queued per clock
// by the stimulus and checked by an independent monitor after each rising edge.
module tb_p_signal_actuator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] cmd;
    logic       lock_open, buzzer, alarm, busy, done;
    logic [7:0] deny_count;

    int total = 0;
    int bad   = 0;
    int exp_dc = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];

    p_signal_actuator #(
        .UNLOCK_CYCLES(5),
        .BEEP_CYCLES  (3),
        .GAP_CYCLES   (2),
        .BEEP_COUNT   (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd       (cmd),
        .lock_open (lock_open),
        .buzzer    (buzzer),
        .alarm     (alarm),
        .busy      (busy),
        .done      (done),
        .deny_count(deny_count)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {lock_open, buzzer, alarm, busy, done, deny_count};
    endfunction

    task automatic compare(input string tag, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got lock=%b buz=%b alm=%b busy=%b done=%b dc=%0d, want lock=%b buz=%b alm=%b busy=%b done=%b dc=%0d",
                     tag, act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Monitor: every rising edge, compare outputs against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                compare(tag_q.pop_front(), outs(), exp_q.pop_front());
        end
    end

    task automatic push(input string tag, input logic l, input logic b, input logic a,
                        input logic bs, input logic d);
        exp_q.push_back({l, b, a, bs, d, 8'(exp_dc)});
        tag_q.push_back(tag);
    endtask

    task automatic step(input logic [1:0] c, input string tag, input logic l, input logic b,
                        input logic a, input logic bs, input logic d);
        @(negedge clk);
        cmd = c;
        push(tag, l, b, a, bs, d);
    endtask

    task automatic idle_steps(input logic [1:0] c, input int n, input string tag);
        for (int i = 0; i < n; i++) step(c, tag, 0, 0, 0, 0, 0);
    endtask

    // Full deny pattern; cmds[k] is the cmd value driven during pattern cycle k (first must be a new 10).
    task automatic deny_pattern(input logic [1:0] cmds[14], input string tag);
        logic pat[13];
        pat = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
        exp_dc = (exp_dc == 255) ? 255 : exp_dc + 1;
        for (int i = 0; i < 13; i++) step(cmds[i], tag, 0, pat[i], 0, 1, 0);
        step(cmds[13], {tag, "_done"}, 0, 0, 0, 0, 1);
    endtask

    logic [1:0] plain[14];
    logic [1:0] toggled[14];

    initial begin
        reset_n = 1'b1;
        cmd     = 2'b00;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 compare("reset_state", outs(), 13'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Grant: 5 cycles unlocked, one done pulse, held 01 does not retrigger
        for (int i = 0; i < 5; i++) step(2'b01, "grant_open", 1, 0, 0, 1, 0);
        step(2'b01, "grant_done", 0, 0, 0, 0, 1);
        idle_steps(2'b01, 3, "grant_hold");

        // Deny pattern 3 on / 2 off / 3 on / 2 off / 3 on
        step(2'b00, "clear", 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) plain[i] = 2'b10;
        deny_pattern(plain, "deny");
        idle_steps(2'b10, 2, "deny_hold");

        // Alarm preempts unlock on its 3rd cycle; 01/10 ignored; 00 clears without done
        step(2'b00, "clear2", 0, 0, 0, 0, 0);
        step(2'b01, "pre_unlock1", 1, 0, 0, 1, 0);
        step(2'b01, "pre_unlock2", 1, 0, 0, 1, 0);
        step(2'b11, "alarm_enter", 0, 1, 1, 1, 0);
        step(2'b11, "alarm_hold", 0, 1, 1, 1, 0);
        step(2'b01, "alarm_ign01", 0, 1, 1, 1, 0);
        step(2'b10, "alarm_ign10", 0, 1, 1, 1, 0);
        idle_steps(2'b00, 8, "alarm_clear");

        // Deny with cmd wiggling mid-pattern: no change, no extra count
        toggled = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01,
                    2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10};
        deny_pattern(toggled, "deny_toggle");
        idle_steps(2'b10, 2, "deny_toggle_hold");

        // Saturation: many more accepted denies, counter must stick at 255
        for (int k = 0; k < 256; k++) begin
            step(2'b00, "sat_clear", 0, 0, 0, 0, 0);
            deny_pattern(plain, "sat_deny");
        end

        // Async reset mid-unlock, release with cmd=01 held
        step(2'b00, "pre_rst_clear", 0, 0, 0, 0, 0);
        step(2'b01, "pre_rst_unlock1", 1, 0, 0, 1, 0);
        step(2'b01, "pre_rst_unlock2", 1, 0, 0, 1, 0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 compare("async_reset", outs(), 13'd0);
        exp_dc = 0;
        repeat (2) @(posedge clk);
        #2 compare("reset_hold", outs(), 13'd0);
        @(negedge clk);
        reset_n = 1'b1;
        push("rst_unlock", 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(2'b01, "rst_unlock", 1, 0, 0, 1, 0);
        step(2'b01, "rst_done", 0, 0, 0, 0, 1);
        idle_steps(2'b01, 2, "rst_hold");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p_signal_actuator.md
P_SIGNAL_ACTUATOR -- requirements
Module: p_signal_actuator

Interface
REQ-001 Parameter: UNLOCK_CYCLES, default 50000000, number of clk cycles lock_open is held high per grant.
REQ-002 Parameter: BEEP_CYCLES, default 5000000, length in cycles of one buzzer-on pulse in the deny pattern.
REQ-003 Parameter: GAP_CYCLES, default 5000000, length in cycles of one buzzer-off gap between deny pulses.
REQ-004 Parameter: BEEP_COUNT, default 3, number of buzzer pulses per deny pattern (legal range 1..15).
REQ-005 clk  input  1  system clock; all logic is rising-edge, single domain with the command PIO.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 cmd  input  2  command code from the PIO out_port: 00 idle/clear, 01 grant, 10 deny, 11 alarm.
REQ-008 lock_open  output  1  door-lock relay drive, high = unlocked.
REQ-009 buzzer  output  1  buzzer drive.
REQ-010 alarm  output  1  alarm indicator, high only in ALARM state.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse on natural completion of a grant or deny sequence.
REQ-013 deny_count  output  8  number of accepted deny commands, saturating at 255.

Function
REQ-014 Block SHALL register cmd into cmd_q every cycle; a "new command" SHALL be flagged in any cycle where cmd != cmd_q.
REQ-015 Commands SHALL be level-change triggered; a held cmd value SHALL NOT retrigger a sequence.
REQ-016 FSM states SHALL be IDLE, UNLOCK, BEEP_ON, BEEP_OFF, ALARM; all outputs SHALL be registered, decoded from next state.
REQ-017 IDLE: new 01 -> UNLOCK; new 10 -> BEEP_ON with pulse counter 0; new 11 -> ALARM; new 00 -> stay IDLE.
REQ-018 Outputs SHALL change at the first rising edge at which the new cmd value is sampled (latency 1 clock from cmd change).
REQ-019 UNLOCK: lock_open=1 for exactly UNLOCK_CYCLES cycles, then IDLE with done=1 for one cycle.
REQ-020 BEEP_ON: buzzer=1 for exactly BEEP_CYCLES cycles; then BEEP_OFF if pulses completed < BEEP_COUNT, else IDLE with done=1.
REQ-021 BEEP_OFF: buzzer=0 for exactly GAP_CYCLES cycles, then BEEP_ON; no trailing gap after the final pulse.
REQ-022 ALARM: buzzer=1, alarm=1, lock_open=0; exit only on new 00 -> IDLE, done SHALL NOT pulse.
REQ-023 New 11 in UNLOCK, BEEP_ON or BEEP_OFF SHALL preempt to ALARM on that edge, clearing lock_open, no done pulse.
REQ-024 New 00, 01 or 10 in UNLOCK, BEEP_ON, BEEP_OFF SHALL be ignored (cmd_q still updates; no deferred action).
REQ-025 New 01/10 in ALARM SHALL be ignored.
REQ-026 deny_count SHALL increment by 1 only when a new 10 is accepted in IDLE, holding at 255.
REQ-027 Duration counter SHALL be 32 bits, loaded with N-1 on state entry, decrementing to 0; pulse counter 4 bits.
REQ-028 lock_open and buzzer SHALL never be high in the same cycle except never; lock_open=1 only in UNLOCK.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, cmd_q=00, counters 0, lock_open=buzzer=alarm=busy=done=0, deny_count=0.
REQ-030 Reset asserted mid-sequence SHALL abort it immediately with no done pulse.
REQ-031 cmd_q resetting to 00 SHALL make a non-zero cmd present at reset release act as a new command on the first edge.

Verification (UNLOCK_CYCLES=5, BEEP_CYCLES=3, GAP_CYCLES=2, BEEP_COUNT=3)
REQ-032 cmd 00->01 at edge 0 -> lock_open high edges 0..4 exactly 5 cycles, done=1 next cycle, busy low afterward; cmd held 01 -> no retrigger.
REQ-033 cmd 00->10 -> buzzer pattern 3 on/2 off/3 on/2 off/3 on (13 cycles), done=1 once, deny_count=1.
REQ-034 cmd 01 then 11 on 3rd unlock cycle -> lock_open drops same edge, alarm=buzzer=1, no done; cmd 00 -> IDLE, all outputs 0.
REQ-035 During deny pattern cmd 10->01->10 -> pattern unchanged, deny_count unchanged; 256 accepted denies -> deny_count=255.
REQ-036 reset_n low mid-UNLOCK -> all outputs 0 asynchronously; release with cmd=01 -> new 5-cycle unlock starts on first edge.
